// File: rtl/tile_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tile_rom_arbiter
//
// Round-robin scheduler that shares one fixed-latency synchronous ROM read port
// (tile/sprite bitmap ROM) between N_REQ drawing requesters in the VGA pixel
// pipeline. At most one ROM read is issued per clock. Each read is tagged with
// the requester id, and the tag travels down a fixed-length pipeline so that the
// returned word is steered back to its issuer with a one-hot valid. Every delay
// is fixed, so downstream stages can match it with their own delay lines.
//
// Ports
//   clk        : pixel clock, rising edge
//   rst        : asynchronous reset, active high
//   en         : 1 = new grants allowed; 0 = no new grants (in-flight reads finish)
//   req        : per-requester level request, held until granted
//   req_addr   : flat address bus, requester i at [i*ADDR_W +: ADDR_W]
//   gnt        : registered one-hot grant pulse (one cycle)
//   rom_en     : registered ROM read strobe
//   rom_addr   : registered ROM address (holds when idle)
//   rom_data   : ROM read data, valid LAT cycles after rom_en
//   resp_valid : registered one-hot response strobe
//   resp_data  : registered read data (holds when no response)
//   busy       : a read is being issued or is still in flight
// -----------------------------------------------------------------------------
module tile_rom_arbiter #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 12,
   parameter int DATA_W = 12,
   parameter int LAT    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   output logic [N_REQ-1:0]          gnt,
   output logic                      rom_en,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_data,
   output logic [N_REQ-1:0]          resp_valid,
   output logic [DATA_W-1:0]         resp_data,
   output logic                      busy
);

   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // ---------------------------------------------------------------------
   // Unpack the flat address bus
   // ---------------------------------------------------------------------
   logic [ADDR_W-1:0] addr_arr [N_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_addr
         assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [N_REQ-1:0]  gnt_q,        gnt_d;
   logic              rom_en_q,     rom_en_d;
   logic [ADDR_W-1:0] rom_addr_q,   rom_addr_d;
   logic [ID_W-1:0]   issue_id_q,   issue_id_d;
   logic [ID_W-1:0]   last_q,       last_d;
   logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_data_q,  resp_data_d;

   // Tag pipeline: {valid, id} per stage. The issue register (rom_en_q /
   // issue_id_q) sits in front of stage 0, so stage LAT-1 holds the tag of the
   // read whose word is on rom_data during the same cycle.
   logic [LAT-1:0]    tag_v_q;
   logic [ID_W-1:0]   tag_id_q [LAT];

   // ---------------------------------------------------------------------
   // Round-robin search
   // ---------------------------------------------------------------------
   // The requester currently seeing gnt is masked: it is changing req/addr on
   // this very edge, so its inputs are not yet its next request.
   logic [N_REQ-1:0]  elig;
   logic              found;
   logic [ID_W-1:0]   win;
   logic [ID_W-1:0]   cand;

   always_comb begin
      elig  = req & ~gnt_q;
      found = 1'b0;
      win   = last_q;
      cand  = '0;
      // Search starts one past the last winner and wraps modulo N_REQ.
      for (int k = 1; k <= N_REQ; k++) begin
         cand = ID_W'((int'(last_q) + k) % N_REQ);
         if (!found && elig[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Next state: issue and response
   // ---------------------------------------------------------------------
   always_comb begin
      gnt_d        = '0;
      rom_en_d     = 1'b0;
      rom_addr_d   = rom_addr_q;
      issue_id_d   = issue_id_q;
      last_d       = last_q;
      resp_valid_d = '0;
      resp_data_d  = resp_data_q;

      if (en && found) begin
         gnt_d[win] = 1'b1;
         rom_en_d   = 1'b1;
         rom_addr_d = addr_arr[win];
         issue_id_d = win;
         last_d     = win;
      end

      if (tag_v_q[LAT-1]) begin
         resp_valid_d[tag_id_q[LAT-1]] = 1'b1;
         resp_data_d                   = rom_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q        <= '0;
         rom_en_q     <= 1'b0;
         rom_addr_q   <= '0;
         issue_id_q   <= '0;
         last_q       <= ID_W'(N_REQ - 1);   // requester 0 wins first
         resp_valid_q <= '0;
         resp_data_q  <= '0;
      end else begin
         gnt_q        <= gnt_d;
         rom_en_q     <= rom_en_d;
         rom_addr_q   <= rom_addr_d;
         issue_id_q   <= issue_id_d;
         last_q       <= last_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
      end
   end

   // ---------------------------------------------------------------------
   // Tag pipeline: shifts every clock, never stalls. Reset discards any
   // in-flight reads.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_v_q <= '0;
         for (int s = 0; s < LAT; s++) begin
            tag_id_q[s] <= '0;
         end
      end else begin
         tag_v_q[0]  <= rom_en_q;
         tag_id_q[0] <= issue_id_q;
         for (int s = 1; s < LAT; s++) begin
            tag_v_q[s]  <= tag_v_q[s-1];
            tag_id_q[s] <= tag_id_q[s-1];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign gnt        = gnt_q;
   assign rom_en     = rom_en_q;
   assign rom_addr   = rom_addr_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign busy       = rom_en_q | (|tag_v_q);

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for tile_rom_arbiter: directed vectors on a LAT=2 instance plus an
// address sweep on a LAT=4 instance. Each instance has a behavioural ROM with
// its own read latency.
// -----------------------------------------------------------------------------
module tb_tile_rom_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;

   // LAT = 2 instance
   logic [3:0]  req2;
   logic [47:0] addr2;
   logic [3:0]  gnt2;
   logic        rom_en2;
   logic [11:0] rom_addr2;
   logic [11:0] rom_data2;
   logic [3:0]  resp_valid2;
   logic [11:0] resp_data2;
   logic        busy2;

   // LAT = 4 instance
   logic [3:0]  req4;
   logic [47:0] addr4;
   logic [3:0]  gnt4;
   logic        rom_en4;
   logic [11:0] rom_addr4;
   logic [11:0] rom_data4;
   logic [3:0]  resp_valid4;
   logic [11:0] resp_data4;
   logic        busy4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   tile_rom_arbiter #(.N_REQ(4), .ADDR_W(12), .DATA_W(12), .LAT(2)) u_dut2 (
      .clk(clk), .rst(rst), .en(en), .req(req2), .req_addr(addr2),
      .gnt(gnt2), .rom_en(rom_en2), .rom_addr(rom_addr2), .rom_data(rom_data2),
      .resp_valid(resp_valid2), .resp_data(resp_data2), .busy(busy2)
   );

   tile_rom_arbiter #(.N_REQ(4), .ADDR_W(12), .DATA_W(12), .LAT(4)) u_dut4 (
      .clk(clk), .rst(rst), .en(en), .req(req4), .req_addr(addr4),
      .gnt(gnt4), .rom_en(rom_en4), .rom_addr(rom_addr4), .rom_data(rom_data4),
      .resp_valid(resp_valid4), .resp_data(resp_data4), .busy(busy4)
   );

   // ROM contents: an arbitrary scramble of the address
   function automatic logic [11:0] rom_f(input logic [11:0] a);
      logic [11:0] m;
      m = 12'(a * 12'd37);
      return m ^ 12'hA5C ^ {a[3:0], a[11:4]};
   endfunction

   // Behavioural ROMs: word for the address seen at edge e appears LAT cycles
   // after the cycle in which it was presented.
   logic [11:0] rp2 [2];
   logic [11:0] rp4 [4];

   always @(posedge clk) begin
      rp2[0] <= rom_f(rom_addr2);
      rp2[1] <= rp2[0];
      rp4[0] <= rom_f(rom_addr4);
      for (int i = 1; i < 4; i++) rp4[i] <= rp4[i-1];
   end
   assign rom_data2 = rp2[1];
   assign rom_data4 = rp4[3];

   // One line per returned read
   always @(negedge clk) begin
      if (resp_valid2 != 4'b0)
         $display("[TB] t=%0t lat2 resp valid=%b data=%h", $time, resp_valid2, resp_data2);
      if (resp_valid4 != 4'b0)
         $display("[TB] t=%0t lat4 resp valid=%b data=%h", $time, resp_valid4, resp_data4);
   end

   // ---------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Checks one cycle of the LAT=2 instance. gid/rid = -1 means no grant /
   // no response expected in this cycle.
   task automatic check_cycle(input string name, input int c, input int gid,
                              input logic [11:0] ea, input int rid, input logic [11:0] ra);
      string p;
      p = $sformatf("%s_c%0d", name, c);
      check_eq({p, "_gnt"},    32'(gnt2),        (gid < 0) ? 32'd0 : (32'd1 << gid));
      check_eq({p, "_rom_en"}, 32'(rom_en2),     (gid < 0) ? 32'd0 : 32'd1);
      if (gid >= 0) check_eq({p, "_rom_addr"}, 32'(rom_addr2), 32'(ea));
      check_eq({p, "_rvalid"}, 32'(resp_valid2), (rid < 0) ? 32'd0 : (32'd1 << rid));
      if (rid >= 0) check_eq({p, "_rdata"}, 32'(resp_data2), 32'(rom_f(ra)));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_base2(input logic [11:0] base);
      for (int i = 0; i < 4; i++) addr2[i*12 +: 12] = base + 12'(i);
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      en   = 1'b1;
      req2 = 4'b0;
      req4 = 4'b0;
      repeat (2) @(posedge clk);
      #1;
      rst  = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Hand-derived vectors (index = cycle-1, cycle 1 follows first edge)
   // ---------------------------------------------------------------------
   int          t1_g  [9]  = '{0, -1, 0, -1, 0, -1, -1, -1, -1};
   logic [11:0] t1_ga [9]  = '{12'h010, 0, 12'h011, 0, 12'h012, 0, 0, 0, 0};
   int          t1_r  [9]  = '{-1, -1, -1, 0, -1, 0, -1, 0, -1};
   logic [11:0] t1_ra [9]  = '{0, 0, 0, 12'h010, 0, 12'h011, 0, 12'h012, 0};

   int t2_g [9]  = '{0, 1, 2, 3, 0, 1, -1, -1, -1};
   int t2_r [9]  = '{-1, -1, -1, 0, 1, 2, 3, 0, 1};

   int t3_g [7]  = '{2, 3, 0, 1, -1, -1, -1};
   int t3_r [7]  = '{-1, -1, -1, 2, 3, 0, 1};

   int t4_g [12] = '{0, 1, 2, -1, -1, -1, -1, 3, 0, -1, -1, -1};
   int t4_r [12] = '{-1, -1, -1, 0, 1, 2, -1, -1, -1, -1, 3, 0};

   int t5_g [6]  = '{0, 1, 2, -1, -1, -1};
   int t5_r [6]  = '{-1, -1, -1, 0, 1, 2};

   int          due_q [$];
   logic [11:0] dat_q [$];

   initial begin
      rst   = 1'b1;
      en    = 1'b1;
      req2  = '0;
      req4  = '0;
      addr2 = '0;
      addr4 = '0;

      // ---- reset state + single requester ---------------------------------
      do_reset();
      check_eq("rst_gnt",      32'(gnt2),        0);
      check_eq("rst_rom_en",   32'(rom_en2),     0);
      check_eq("rst_rom_addr", 32'(rom_addr2),   0);
      check_eq("rst_rvalid",   32'(resp_valid2), 0);
      check_eq("rst_rdata",    32'(resp_data2),  0);
      check_eq("rst_busy",     32'(busy2),       0);
      check_eq("rst_busy4",    32'(busy4),       0);

      addr2[11:0] = 12'h010;
      req2        = 4'b0001;
      for (int c = 1; c <= 9; c++) begin
         tick();
         check_cycle("t1", c, t1_g[c-1], t1_ga[c-1], t1_r[c-1], t1_ra[c-1]);
         if (gnt2[0]) addr2[11:0] = addr2[11:0] + 12'd1;
         if (c == 5) req2 = 4'b0;
      end

      // ---- all four requesting -------------------------------------------
      do_reset();
      set_base2(12'h100);
      req2 = 4'b1111;
      for (int c = 1; c <= 9; c++) begin
         tick();
         check_cycle("t2", c, t2_g[c-1], 12'h100 + 12'(t2_g[c-1]),
                     t2_r[c-1], 12'h100 + 12'(t2_r[c-1]));
         if (c == 6) req2 = 4'b0;
      end

      // ---- contention after a wrap: last_winner=2, req=1011 ----------------
      do_reset();
      set_base2(12'h200);
      req2 = 4'b0100;
      for (int c = 1; c <= 7; c++) begin
         tick();
         check_cycle("t3", c, t3_g[c-1], 12'h200 + 12'(t3_g[c-1]),
                     t3_r[c-1], 12'h200 + 12'(t3_r[c-1]));
         if (c == 1) req2 = 4'b1011;
         if (c == 4) req2 = 4'b0;
      end

      // ---- en=0 with three reads in flight ---------------------------------
      do_reset();
      set_base2(12'h300);
      req2 = 4'b1111;
      for (int c = 1; c <= 12; c++) begin
         tick();
         check_cycle("t4", c, t4_g[c-1], 12'h300 + 12'(t4_g[c-1]),
                     t4_r[c-1], 12'h300 + 12'(t4_r[c-1]));
         if (c == 3 || c == 4 || c == 10) check_eq($sformatf("t4_c%0d_busy", c), 32'(busy2), 1);
         if (c == 7 || c == 12)           check_eq($sformatf("t4_c%0d_busy", c), 32'(busy2), 0);
         if (c == 3) en = 1'b0;
         if (c == 7) en = 1'b1;
         if (c == 9) req2 = 4'b0;
      end

      // ---- reset mid-stream ------------------------------------------------
      do_reset();
      set_base2(12'h400);
      req2 = 4'b1111;
      tick();
      check_cycle("t5pre", 1, 0, 12'h400, -1, 0);
      tick();
      check_cycle("t5pre", 2, 1, 12'h401, -1, 0);
      rst = 1'b1;
      #1;
      check_eq("t5_rst_gnt",      32'(gnt2),        0);
      check_eq("t5_rst_rom_en",   32'(rom_en2),     0);
      check_eq("t5_rst_rom_addr", 32'(rom_addr2),   0);
      check_eq("t5_rst_rvalid",   32'(resp_valid2), 0);
      check_eq("t5_rst_rdata",    32'(resp_data2),  0);
      check_eq("t5_rst_busy",     32'(busy2),       0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         check_cycle("t5", c, t5_g[c-1], 12'h400 + 12'(t5_g[c-1]),
                     t5_r[c-1], 12'h400 + 12'(t5_r[c-1]));
         if (c == 3) req2 = 4'b0;
      end

      // ---- LAT=4: 5-cycle offset and ROM sweep 0x000..0x0FF ----------------
      do_reset();
      begin
         int cur;
         cur          = 0;
         addr4[11:0]  = 12'h000;
         req4         = 4'b0001;
         for (int c = 1; c <= 700 && (cur < 256 || due_q.size() > 0); c++) begin
            tick();
            // single requester: grants land on odd cycles only
            check_eq($sformatf("t6_c%0d_gnt", c), 32'(gnt4),
                     ((c % 2 == 1) && cur < 256) ? 32'd1 : 32'd0);
            if (gnt4 != 4'b0) begin
               check_eq($sformatf("t6_c%0d_rom_addr", c), 32'(rom_addr4), 32'(cur));
               due_q.push_back(c + 5);
               dat_q.push_back(rom_f(12'(cur)));
               cur++;
               if (cur == 256) req4 = 4'b0;
               else            addr4[11:0] = 12'(cur);
            end
            if (due_q.size() > 0 && due_q[0] == c) begin
               check_eq($sformatf("t6_c%0d_rvalid", c), 32'(resp_valid4), 32'd1);
               check_eq($sformatf("t6_c%0d_rdata", c),  32'(resp_data4),  32'(dat_q[0]));
               void'(due_q.pop_front());
               void'(dat_q.pop_front());
            end else begin
               check_eq($sformatf("t6_c%0d_rvalid", c), 32'(resp_valid4), 32'd0);
            end
         end
         check_eq("t6_reads_issued", 32'(cur), 32'd256);
         check_eq("t6_resp_pending", 32'(due_q.size()), 32'd0);
         check_eq("t6_busy_idle",    32'(busy4), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
